// File: rtl/uart_6502_pkg.sv
// ============================================================================
// uart_6502_pkg : register map, bit positions and serializer states shared by
//                 the 6502-bus UART transmit peripheral.
// Revision      : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package uart_6502_pkg;

  localparam logic [1:0] TX_DATA   = 2'd0;
  localparam logic [1:0] TX_STATUS = 2'd1;
  localparam logic [1:0] TX_LEVEL  = 2'd2;
  localparam logic [1:0] TX_CTRL   = 2'd3;

  localparam int STAT_EMPTY    = 0;
  localparam int STAT_FULL     = 1;
  localparam int STAT_ACTIVE   = 2;
  localparam int STAT_OVERFLOW = 3;

  localparam int CTRL_CLR_OVF  = 0;
  localparam int CTRL_FLUSH    = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_tx_serializer.sv
// ============================================================================
// uart_tx_serializer : 8N1 bit engine with a valid/ready byte input.
// Revision           : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_tx_serializer
  import uart_6502_pkg::*;
#(
  parameter int BaudDiv = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       byte_valid_i,
  output logic       byte_ready_o,
  input  logic [7:0] byte_i,
  output logic       uart_tx_o,
  output logic       busy_o
);

  localparam int                c_cnt_w    = (BaudDiv > 2) ? $clog2(BaudDiv) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(BaudDiv - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  tx_state_t          state_q, state_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;

  logic w_last;
  logic w_accept;

  assign w_last       = (cnt_q == c_cnt_last);
  // Accepting on the last STOP cycle gives back-to-back frames with no idle gap.
  assign byte_ready_o = (state_q == IDLE) || ((state_q == STOP) && w_last);
  assign w_accept     = byte_valid_i && byte_ready_o;
  assign uart_tx_o    = tx_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    if (w_accept) begin
      state_d = START;
      cnt_d   = '0;
      bit_d   = '0;
      shift_d = byte_i;
    end else begin
      case (state_q)
        START: begin
          if (w_last) begin
            state_d = DATA;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + c_cnt_one;
          end
        end
        DATA: begin
          if (w_last) begin
            cnt_d   = '0;
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            if (bit_q == 3'd7) state_d = STOP;
          end else begin
            cnt_d = cnt_q + c_cnt_one;
          end
        end
        STOP: begin
          if (w_last) state_d = IDLE;
          else        cnt_d   = cnt_q + c_cnt_one;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tx_d   = 1'b1;
    busy_o = (state_q != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo_6502.sv
// ============================================================================
// uart_tx_fifo_6502 : buffered 8N1 UART transmitter on the 6502 bus
//                     (TX FIFO, status/level/control registers).
// Revision          : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_tx_fifo_6502
  import uart_6502_pkg::*;
#(
  parameter int BaseAddress   = 0,
  parameter int FPGAClkSpeed  = 0,
  parameter int UARTBaudRate  = 0,
  parameter int FifoDepthLog2 = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [15:0] address_i,
  input  logic [7:0]  data_i,
  output logic [7:0]  data_o,
  input  logic        rd_wr_i,
  output logic        take_controlr_o,
  output logic        take_controlw_o,
  output logic        uart_tx_o
);

  localparam int c_baud_div = (UARTBaudRate > 0) ? (FPGAClkSpeed / UARTBaudRate) : 0;
  localparam int c_depth    = 2 ** FifoDepthLog2;
  localparam logic [FifoDepthLog2:0]   c_full_cnt = {1'b1, {FifoDepthLog2{1'b0}}};
  localparam logic [FifoDepthLog2:0]   c_cnt_one  = {{FifoDepthLog2{1'b0}}, 1'b1};
  localparam logic [FifoDepthLog2-1:0] c_ptr_one  = {{(FifoDepthLog2-1){1'b0}}, 1'b1};

  generate
    if (c_baud_div < 2) begin : g_bad_baud
      $error("uart_tx_fifo_6502: FPGAClkSpeed/UARTBaudRate must be at least 2");
    end
    if (FifoDepthLog2 < 2 || FifoDepthLog2 > 7) begin : g_bad_depth
      $error("uart_tx_fifo_6502: FifoDepthLog2 must be in 2..7");
    end
  endgenerate

  logic [7:0]               mem_q [c_depth];
  logic [FifoDepthLog2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FifoDepthLog2:0]   count_q, count_d;
  logic                     ovf_q, ovf_d;
  logic [7:0]               data_q, data_d;
  logic                     tcr_q, tcr_d, tcw_q, tcw_d;

  logic [15:0] w_off;
  logic        w_hit, w_push_req, w_ctrl_wr, w_rd_status, w_rd_level;
  logic        w_full, w_empty, w_push, w_pop, w_flush;
  logic        w_ser_ready, w_ser_busy;
  logic [7:0]  w_status, w_level;

  // Subtracting the base keeps the decode correct even if the window wraps.
  assign w_off       = address_i - 16'(BaseAddress);
  assign w_hit       = (w_off < 16'd4);
  assign w_push_req  = w_hit &&  rd_wr_i && (w_off[1:0] == TX_DATA);
  assign w_ctrl_wr   = w_hit &&  rd_wr_i && (w_off[1:0] == TX_CTRL);
  assign w_rd_status = w_hit && !rd_wr_i && (w_off[1:0] == TX_STATUS);
  assign w_rd_level  = w_hit && !rd_wr_i && (w_off[1:0] == TX_LEVEL);

  assign w_full  = (count_q == c_full_cnt);
  assign w_empty = (count_q == '0);
  assign w_push  = w_push_req && !w_full;
  assign w_pop   = w_ser_ready && !w_empty;
  assign w_flush = w_ctrl_wr && data_i[CTRL_FLUSH];

  uart_tx_serializer #(
    .BaudDiv (c_baud_div)
  ) u_ser (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .byte_valid_i (!w_empty),
    .byte_ready_o (w_ser_ready),
    .byte_i       (mem_q[rd_ptr_q]),
    .uart_tx_o    (uart_tx_o),
    .busy_o       (w_ser_busy)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + c_ptr_one;
      if (w_pop)  rd_ptr_d = rd_ptr_q + c_ptr_one;
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + c_cnt_one;
        2'b01:   count_d = count_q - c_cnt_one;
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (w_push_req && w_full)                     ovf_d = 1'b1;
    else if (w_ctrl_wr && data_i[CTRL_CLR_OVF])   ovf_d = 1'b0;
  end

  always_comb begin
    w_status                = '0;
    w_status[STAT_EMPTY]    = w_empty;
    w_status[STAT_FULL]     = w_full;
    w_status[STAT_ACTIVE]   = w_ser_busy;
    w_status[STAT_OVERFLOW] = ovf_q;
    w_level                 = '0;
    w_level[FifoDepthLog2:0] = count_q;
    data_d = w_rd_status ? w_status : (w_rd_level ? w_level : 8'h00);
    tcr_d  = w_rd_status || w_rd_level;
    tcw_d  = w_push_req || w_ctrl_wr;
  end

  always_ff @(posedge clk_i) begin
    if (w_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      data_q   <= '0;
      tcr_q    <= 1'b0;
      tcw_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      data_q   <= data_d;
      tcr_q    <= tcr_d;
      tcw_q    <= tcw_d;
    end
  end

  assign data_o          = data_q;
  assign take_controlr_o = tcr_q;
  assign take_controlw_o = tcw_q;

endmodule

`default_nettype wire
